// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode constants and data width for the datapath ALU
//   DATA_W   : datapath width (8)
//   alu_op_e : 4-bit operation codes ALU_ADD .. ALU_RSVD, shared with the control unit
package alu_pkg;
    localparam int DATA_W = 8;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10,
        ALU_NOTA = 4'd11,
        ALU_PASSB = 4'd12,
        ALU_INC  = 4'd13,
        ALU_DEC  = 4'd14,
        ALU_RSVD = 4'd15
    } alu_op_e;
endpackage

// File: rtl/alu_if.sv
// alu_if: operand/control/result bundle between control unit and ALU
//   SrcA, SrcB, ALUControl : operands and operation select (master drives)
//   ALUResult, Zero        : registered result and zero flag (slave drives)
//   Carry, Overflow, Negative : extra flags, only with ALU_EXT_FLAGS_EN
interface alu_if;
    import alu_pkg::*;
    logic [DATA_W-1:0] SrcA;
    logic [DATA_W-1:0] SrcB;
    logic [3:0]        ALUControl;
    logic [DATA_W-1:0] ALUResult;
    logic              Zero;
`ifdef ALU_EXT_FLAGS_EN
    logic              Carry;
    logic              Overflow;
    logic              Negative;
    modport master (output SrcA, SrcB, ALUControl, input ALUResult, Zero, Carry, Overflow, Negative);
    modport slave  (input SrcA, SrcB, ALUControl, output ALUResult, Zero, Carry, Overflow, Negative);
`else
    modport master (output SrcA, SrcB, ALUControl, input ALUResult, Zero);
    modport slave  (input SrcA, SrcB, ALUControl, output ALUResult, Zero);
`endif
endinterface

// File: rtl/alu_shifter.sv
// alu_shifter: combinational 8-bit logical left, logical right and arithmetic right shifts
//   a     : value to shift
//   shamt : shift amount 0..7
//   sll, srl, sra : shifted results (zero fill, zero fill, sign fill)
module alu_shifter
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [2:0]        shamt,
    output logic [DATA_W-1:0] sll,
    output logic [DATA_W-1:0] srl,
    output logic [DATA_W-1:0] sra
);
    assign sll = a << shamt;
    assign srl = a >> shamt;
    assign sra = $signed(a) >>> shamt;
endmodule

// File: rtl/alu.sv
// alu: registered 8-bit ALU, 16 ops, result and Zero loaded every clock
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (ALUResult=0, Zero=1, flags=0)
//   bus   : alu_if.slave (SrcA, SrcB, ALUControl in; ALUResult, Zero out)
//   ALU_EXT_FLAGS_EN : adds registered Carry, Overflow, Negative
module alu
    import alu_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    alu_if.slave bus
);
    logic [DATA_W-1:0] a, b, sll, srl, sra, res;
    alu_op_e op;
    assign a  = bus.SrcA;
    assign b  = bus.SrcB;
    assign op = alu_op_e'(bus.ALUControl);
    alu_shifter u_shifter (.a(a), .shamt(b[2:0]), .sll(sll), .srl(srl), .sra(sra));
    always_comb begin
        res = '0;
        case (op)
            ALU_ADD:   res = a + b;
            ALU_SUB:   res = a - b;
            ALU_AND:   res = a & b;
            ALU_OR:    res = a | b;
            ALU_XOR:   res = a ^ b;
            ALU_NOR:   res = ~(a | b);
            ALU_SLL:   res = sll;
            ALU_SRL:   res = srl;
            ALU_SRA:   res = sra;
            ALU_SLT:   res = {7'd0, $signed(a) < $signed(b)};
            ALU_SLTU:  res = {7'd0, a < b};
            ALU_NOTA:  res = ~a;
            ALU_PASSB: res = b;
            ALU_INC:   res = a + 8'd1;
            ALU_DEC:   res = a - 8'd1;
            default:   res = '0;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ALUResult <= '0;
            bus.Zero      <= 1'b1;
        end else begin
            bus.ALUResult <= res;
            bus.Zero      <= res == '0;
        end
    end
`ifdef ALU_EXT_FLAGS_EN
    logic c, v;
    // Carry is carry-out for ADD/INC and borrow for SUB/DEC; overflow uses operand/result sign bits
    always_comb begin
        c = 1'b0;
        v = 1'b0;
        case (op)
            ALU_ADD: begin
                c = (9'(a) + 9'(b)) > 9'd255;
                v = (a[7] == b[7]) && (res[7] != a[7]);
            end
            ALU_SUB: begin
                c = a < b;
                v = (a[7] != b[7]) && (res[7] != a[7]);
            end
            ALU_INC: begin
                c = a == 8'hFF;
                v = a == 8'h7F;
            end
            ALU_DEC: begin
                c = a == 8'h00;
                v = a == 8'h80;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.Carry    <= 1'b0;
            bus.Overflow <= 1'b0;
            bus.Negative <= 1'b0;
        end else begin
            bus.Carry    <= c;
            bus.Overflow <= v;
            bus.Negative <= res[7];
        end
    end
`endif
endmodule

// File: tb/tb_alu.sv
// tb_alu: self-checking bench for alu with directed cases and randomized ops against an arithmetic model
module tb_alu;
    import alu_pkg::*;
    logic clk = 1'b0;
    logic clk_en = 1'b1;
    logic rst_n = 1'b0;
    int checks = 0;
    int passes = 0;
    alu_if bus ();
    alu dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 if (clk_en) clk = ~clk;
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s got=0x%02h exp=0x%02h", tag, got, exp);
    endtask
    function automatic int sgn(input int x);
        return x > 127 ? x - 256 : x;
    endfunction
    function automatic logic [7:0] ref_res(input int a, input int b, input int op);
        int sh, d, q;
        sh = b % 8;
        d = 1 << sh;
        case (op)
            0:  return 8'((a + b) % 256);
            1:  return 8'((a - b + 256) % 256);
            2:  return 8'(a & b);
            3:  return 8'(a | b);
            4:  return 8'(a ^ b);
            5:  return 8'(255 - (a | b));
            6:  return 8'((a * d) % 256);
            7:  return 8'(a / d);
            8: begin
                q = sgn(a) / d;
                if (sgn(a) < 0 && q * d != sgn(a)) q--;
                return 8'((q + 256) % 256);
            end
            9:  return sgn(a) < sgn(b) ? 8'd1 : 8'd0;
            10: return a < b ? 8'd1 : 8'd0;
            11: return 8'(255 - a);
            12: return 8'(b);
            13: return 8'((a + 1) % 256);
            14: return 8'((a + 255) % 256);
            default: return 8'd0;
        endcase
    endfunction
    function automatic logic ref_carry(input int a, input int b, input int op);
        case (op)
            0:  return a + b > 255;
            1:  return a < b;
            13: return a == 255;
            14: return a == 0;
            default: return 1'b0;
        endcase
    endfunction
    function automatic logic ref_ovf(input int a, input int b, input int op);
        int s;
        case (op)
            0:  s = sgn(a) + sgn(b);
            1:  s = sgn(a) - sgn(b);
            13: s = sgn(a) + 1;
            14: s = sgn(a) - 1;
            default: s = 0;
        endcase
        return s > 127 || s < -128;
    endfunction
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op, input string tag);
        logic [7:0] e;
        bus.SrcA = a;
        bus.SrcB = b;
        bus.ALUControl = op;
        @(posedge clk);
        #1;
        e = ref_res(int'(a), int'(b), int'(op));
        chk({tag, "_res"}, bus.ALUResult, e);
        chk({tag, "_zero"}, 8'(bus.Zero), 8'(e == 8'd0));
`ifdef ALU_EXT_FLAGS_EN
        chk({tag, "_carry"}, 8'(bus.Carry), 8'(ref_carry(int'(a), int'(b), int'(op))));
        chk({tag, "_ovf"}, 8'(bus.Overflow), 8'(ref_ovf(int'(a), int'(b), int'(op))));
        chk({tag, "_neg"}, 8'(bus.Negative), 8'(e[7]));
`endif
    endtask
    logic [7:0] sweep_exp [16] = '{8'h06, 8'hFE, 8'h00, 8'h06, 8'h06, 8'hF9, 8'h20, 8'h00,
                                   8'h00, 8'h01, 8'h01, 8'hFD, 8'h04, 8'h03, 8'h01, 8'h00};
    initial begin
        bus.SrcA = 8'h55;
        bus.SrcB = 8'h22;
        bus.ALUControl = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_res", bus.ALUResult, 8'h00);
        chk("rst_zero", 8'(bus.Zero), 8'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step(8'h02, 8'h04, 4'(i), $sformatf("sweep%0d", i));
            chk($sformatf("sweep%0d_tbl", i), bus.ALUResult, sweep_exp[i]);
            chk($sformatf("sweep%0d_ztbl", i), 8'(bus.Zero), 8'(i == 2 || i == 7 || i == 8 || i == 15));
        end
        step(8'hFF, 8'h01, 4'(ALU_ADD), "wrap_add");
        chk("wrap_add_tbl", bus.ALUResult, 8'h00);
`ifdef ALU_EXT_FLAGS_EN
        chk("wrap_add_carry_tbl", 8'(bus.Carry), 8'd1);
`endif
        step(8'hFF, 8'h01, 4'(ALU_INC), "wrap_inc");
        chk("wrap_inc_tbl", bus.ALUResult, 8'h00);
        step(8'h80, 8'h07, 4'(ALU_SRA), "sra");
        chk("sra_tbl", bus.ALUResult, 8'hFF);
        step(8'h80, 8'h01, 4'(ALU_SLT), "slt");
        chk("slt_tbl", bus.ALUResult, 8'h01);
        step(8'h80, 8'h01, 4'(ALU_SLTU), "sltu");
        chk("sltu_tbl", bus.ALUResult, 8'h00);
        step(8'h80, 8'h01, 4'(ALU_SUB), "sub_ovf");
        chk("sub_ovf_tbl", bus.ALUResult, 8'h7F);
`ifdef ALU_EXT_FLAGS_EN
        chk("sub_ovf_flag_tbl", 8'(bus.Overflow), 8'd1);
`endif
        step(8'h10, 8'h20, 4'(ALU_ADD), "lat0");
        bus.SrcA = 8'h01;
        bus.SrcB = 8'h01;
        #2;
        chk("lat_hold1", bus.ALUResult, 8'h30);
        bus.SrcA = 8'h05;
        bus.SrcB = 8'h03;
        bus.ALUControl = 4'(ALU_SUB);
        #2;
        chk("lat_hold2", bus.ALUResult, 8'h30);
        @(posedge clk);
        #1;
        chk("lat_latest", bus.ALUResult, 8'h02);
        step(8'h02, 8'h04, 4'd15, "cwrap15");
        chk("cwrap15_tbl", bus.ALUResult, 8'h00);
        step(8'h02, 8'h04, 4'd0, "cwrap0");
        chk("cwrap0_tbl", bus.ALUResult, 8'h06);
        step(8'h81, 8'h81, 4'(ALU_ADD), "pre_rst");
        @(negedge clk);
        clk_en = 1'b0;
        #7;
        rst_n = 1'b0;
        #1;
        chk("midrst_res", bus.ALUResult, 8'h00);
        chk("midrst_zero", 8'(bus.Zero), 8'd1);
`ifdef ALU_EXT_FLAGS_EN
        chk("midrst_carry", 8'(bus.Carry), 8'd0);
        chk("midrst_ovf", 8'(bus.Overflow), 8'd0);
        chk("midrst_neg", 8'(bus.Negative), 8'd0);
`endif
        #3;
        rst_n = 1'b1;
        #3;
        chk("postrst_hold", bus.ALUResult, 8'h00);
        clk_en = 1'b1;
        step(8'h03, 8'h04, 4'(ALU_ADD), "first_cap");
        chk("first_cap_tbl", bus.ALUResult, 8'h07);
        for (int i = 0; i < 300; i++)
            step(8'($urandom), 8'($urandom), 4'($urandom_range(15)), $sformatf("rnd%0d", i));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
